// File: rtl/conf_loader_pkg.sv
// Shared definitions for the configuration frame loader: frame-parser
// state encoding and the default frame parameters.
package conf_loader_pkg;

  localparam int unsigned CONF_PAR_NUM_DEF     = 6;
  localparam logic [7:0]  CONF_SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned CONF_GAP_CNT_MAX_DEF = 52 * 10 * 3;

  // Frame parser states
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } conf_state_e;

endpackage : conf_loader_pkg

// File: rtl/conf_loader.sv
// Configuration frame loader.
// Parses frames of the form SYNC_BYTE, PAR_NUM payload bytes, 8-bit sum
// checksum from a UART byte stream. A frame with a matching checksum is
// committed atomically to conf_bus; a checksum mismatch or an inter-byte
// gap reaching GAP_CNT_MAX aborts the frame and pulses frame_err.
// Ports:
//   clk         - system clock, posedge
//   rst_n       - synchronous active-low reset
//   rx_data     - received byte
//   rx_valid    - one-cycle strobe qualifying rx_data
//   conf_bus    - committed parameters, byte k at [8k+7:8k]
//   conf_update - one-cycle pulse when conf_bus is updated
//   conf_valid  - high once any frame has been committed
//   frame_err   - one-cycle pulse on checksum mismatch or gap timeout
module conf_loader
  import conf_loader_pkg::*;
#(
  parameter int unsigned PAR_NUM     = CONF_PAR_NUM_DEF,
  parameter logic [7:0]  SYNC_BYTE   = CONF_SYNC_BYTE_DEF,
  parameter int unsigned GAP_CNT_MAX = CONF_GAP_CNT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [PAR_NUM*8-1:0] conf_bus,
  output logic                 conf_update,
  output logic                 conf_valid,
  output logic                 frame_err
);

  localparam int unsigned IDX_W = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CNT_MAX + 1);
  localparam int unsigned BUS_W = PAR_NUM * 8;

  conf_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [BUS_W-1:0]   shadow_q, shadow_d;
  logic [BUS_W-1:0]   bus_q, bus_d;
  logic               update_q, update_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  // Gap timeout fires on the edge where the count would reach GAP_CNT_MAX
  // without a byte; a byte on that same edge takes priority.
  logic gap_expire_c;
  assign gap_expire_c = (gap_q == GAP_W'(GAP_CNT_MAX - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      sum_q    <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
      bus_q    <= '0;
      update_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      bus_q    <= bus_d;
      update_q <= update_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    bus_d    = bus_q;
    update_d = 1'b0;
    valid_d  = valid_q;
    err_d    = 1'b0;

    case (state_q)
      ST_HUNT: begin
        gap_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          // Payload bytes equal to SYNC_BYTE are plain data here.
          for (int unsigned k = 0; k < PAR_NUM; k++) begin
            if (idx_q == IDX_W'(k)) begin
              shadow_d[8*k +: 8] = rx_data;
            end
          end
          sum_d = sum_q + rx_data;
          gap_d = '0;
          if (idx_q == IDX_W'(PAR_NUM - 1)) begin
            state_d = ST_CHECK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (gap_expire_c) begin
          state_d = ST_HUNT;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          state_d = ST_HUNT;
          gap_d   = '0;
          if (rx_data == sum_q) begin
            bus_d    = shadow_q;
            update_d = 1'b1;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (gap_expire_c) begin
          state_d = ST_HUNT;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_HUNT;
        gap_d   = '0;
      end
    endcase
  end

  assign conf_bus    = bus_q;
  assign conf_update = update_q;
  assign conf_valid  = valid_q;
  assign frame_err   = err_q;

endmodule : conf_loader

// File: tb/tb_conf_loader.sv
// Scoreboard bench for conf_loader: a frame-level reference model pushes
// expected commit/error events, a negedge monitor pops and compares them.
module tb_conf_loader;

  localparam int unsigned PAR_NUM = 6;
  localparam int unsigned GAP     = 1560;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int unsigned BUS_W   = PAR_NUM * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic [BUS_W-1:0] conf_bus;
  logic             conf_update;
  logic             conf_valid;
  logic             frame_err;

  conf_loader #(
    .PAR_NUM    (PAR_NUM),
    .SYNC_BYTE  (SYNC),
    .GAP_CNT_MAX(GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .conf_bus   (conf_bus),
    .conf_update(conf_update),
    .conf_valid (conf_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_err;
    int               neg;
    logic [BUS_W-1:0] bus;
  } ev_t;

  ev_t              exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               neg_cnt = 0;
  bit               mon_on = 1'b0;

  // Reference model state: frame-level view of the byte stream
  bit               in_frame = 1'b0;
  byte unsigned     frame_buf[$];
  int               last_s = 0;
  logic [BUS_W-1:0] m_bus = '0;
  bit               m_valid = 1'b0;

  // Called before idle cycles: a long silence inside a frame is a timeout.
  task automatic model_idle(input int idle);
    if (in_frame && idle >= int'(GAP)) begin
      exp_q.push_back('{is_err: 1'b1, neg: last_s + int'(GAP), bus: m_bus});
      in_frame = 1'b0;
    end
  endtask

  // Called after a byte strobe edge; s is the negedge index following it.
  task automatic model_byte(input byte unsigned b, input int s);
    byte unsigned sum;
    last_s = s;
    if (!in_frame) begin
      if (b == SYNC) begin
        in_frame = 1'b1;
        frame_buf.delete();
      end
    end else begin
      frame_buf.push_back(b);
      if (frame_buf.size() == PAR_NUM + 1) begin
        sum = 0;
        for (int k = 0; k < int'(PAR_NUM); k++) sum = sum + frame_buf[k];
        if (sum == frame_buf[PAR_NUM]) begin
          for (int k = 0; k < int'(PAR_NUM); k++) m_bus[8*k +: 8] = frame_buf[k];
          m_valid = 1'b1;
          exp_q.push_back('{is_err: 1'b0, neg: s, bus: m_bus});
        end else begin
          exp_q.push_back('{is_err: 1'b1, neg: s, bus: m_bus});
        end
        in_frame = 1'b0;
      end
    end
  endtask

  // Inputs change 1 time unit after posedge; idle = empty cycles before the strobe.
  task automatic send(input byte unsigned b, input int idle);
    model_idle(idle);
    if (idle > 0) begin
      repeat (idle) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    model_byte(b, neg_cnt + 1);
  endtask

  task automatic wait_idle(input int n);
    model_idle(n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input byte unsigned p[PAR_NUM], input bit bad, input int max_idle);
    byte unsigned sum;
    sum = 0;
    send(SYNC, $urandom_range(0, max_idle));
    for (int k = 0; k < int'(PAR_NUM); k++) begin
      send(p[k], $urandom_range(0, max_idle));
      sum = sum + p[k];
    end
    if (bad) sum = sum + byte'($urandom_range(1, 255));
    send(sum, $urandom_range(0, max_idle));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    in_frame = 1'b0;
    m_bus    = '0;
    m_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: pops expected events, flags missing, unexpected or late pulses.
  always @(negedge clk) begin
    neg_cnt++;
    if (mon_on) begin
      chk("conf_bus", conf_bus, m_bus);
      chk("conf_valid", BUS_W'(conf_valid), BUS_W'(m_valid));
      if (conf_update && frame_err) chk("pulse_overlap", 1, 0);
      if (conf_update || frame_err) begin
        if (exp_q.size() == 0) begin
          chk(conf_update ? "unexpected_update" : "unexpected_err", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind_err", BUS_W'(frame_err), BUS_W'(e.is_err));
          chk("event_cycle", BUS_W'(neg_cnt), BUS_W'(e.neg));
          if (!e.is_err) chk("commit_bus", conf_bus, e.bus);
        end
      end else if (exp_q.size() != 0 && exp_q[0].neg <= neg_cnt) begin
        chk("missing_event_at", BUS_W'(neg_cnt), BUS_W'(0));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    byte unsigned p[PAR_NUM];
    byte unsigned junk;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_bus", conf_bus, '0);
    chk("reset_valid", BUS_W'(conf_valid), '0);
    chk("reset_update", BUS_W'(conf_update), '0);
    chk("reset_err", BUS_W'(frame_err), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reference frame commit
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(SYNC, 2);
    for (int k = 0; k < 6; k++) send(p[k], 0);
    send(8'h15, 0);
    wait_idle(3);
    chk("ref_bus", conf_bus, 48'h060504030201);
    chk("ref_valid", BUS_W'(conf_valid), 1);

    // Checksum error: bus unchanged
    send(SYNC, 1);
    for (int k = 0; k < 6; k++) send(p[k], 1);
    send(8'h16, 0);
    wait_idle(3);
    chk("cks_err_bus", conf_bus, 48'h060504030201);

    // Sync byte as payload data
    send(SYNC, 0);
    send(SYNC, 0);
    for (int k = 0; k < 5; k++) send(8'h00, 0);
    send(8'hA5, 0);
    wait_idle(3);
    chk("sync_in_payload_bus", conf_bus, 48'h0000000000A5);

    // Timeout mid-frame, then a valid frame
    send(SYNC, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    wait_idle(GAP + 20);
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(p, 1'b0, 2);
    wait_idle(3);
    chk("after_timeout_bus", conf_bus, 48'h665544332211);

    // Reset mid-frame, then a valid frame
    send(SYNC, 0);
    for (int k = 0; k < 3; k++) send(8'h77, 0);
    do_reset();
    chk("mid_reset_bus", conf_bus, '0);
    p = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    send_frame(p, 1'b0, 1);
    wait_idle(3);
    chk("after_reset_bus", conf_bus, 48'h605040302010);

    // Byte arriving exactly GAP cycles after the previous one is accepted
    send(SYNC, 0);
    send(8'h01, 0);
    send(8'h02, GAP - 1);
    for (int k = 0; k < 4; k++) send(8'h03, 0);
    send(8'h0F, GAP - 1);
    wait_idle(3);
    chk("boundary_bus", conf_bus, 48'h03030303_0201);

    // One cycle later than the boundary is a timeout
    send(SYNC, 0);
    send(8'h09, GAP);
    wait_idle(3);

    // Randomized frames with junk, bad checksums and idle gaps
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = $urandom_range(0, 255);
        if (junk == SYNC) junk = 8'h00;
        send(junk, $urandom_range(0, 3));
      end
      for (int k = 0; k < int'(PAR_NUM); k++) p[k] = $urandom_range(0, 255);
      if (n % 20 == 7) begin
        send(SYNC, 0);
        send(p[0], 0);
        wait_idle(GAP + $urandom_range(0, 5));
      end else begin
        send_frame(p, ($urandom_range(0, 3) == 0), 3);
      end
    end
    wait_idle(5);

    chk("queue_drained", BUS_W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, actual running required finished");
    $fatal(1);
  end

endmodule : tb_conf_loader
